// File: rtl/alu_operand_regs.sv
// Operand A/B staging registers for the ALU with a load-tracking FSM,
// tri-state bus drive, latched result flags and sticky error reporting.
module alu_operand_regs #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    inout  wire  [WIDTH-1:0] Bus,
    input  logic             AIn,
    input  logic             BIn,
    input  logic             AOut,
    input  logic             BOut,
    input  logic             SumOut,
    input  logic [1:0]       FlagsIn,
    output logic [WIDTH-1:0] Reg1,
    output logic [WIDTH-1:0] Reg2,
    output logic [1:0]       Flags,
    output logic             Ready,
    output logic [1:0]       Err
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       flags_q;
    logic [1:0]       err_q;
    logic             conflict;
    logic             drive_a;
    logic             drive_b;
    logic             result_ok;

    // Two or more bus sources requested at once: nobody from here drives.
    assign conflict = (AOut & BOut) | (AOut & SumOut) | (BOut & SumOut);
    assign drive_a  = Rst & AOut & ~BOut & ~SumOut;
    assign drive_b  = Rst & BOut & ~AOut & ~SumOut;
    assign Bus      = drive_a ? a_q : (drive_b ? b_q : {WIDTH{1'bz}});

    assign result_ok = SumOut && (state == READY);

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (AIn && BIn) state_nx = READY;
                else if (AIn)   state_nx = HAVE_A;
                else if (BIn)   state_nx = HAVE_B;
            end
            HAVE_A:  if (BIn) state_nx = READY;
            HAVE_B:  if (AIn) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = EMPTY;
        endcase
        // A consumed result overrides any simultaneous load transition.
        if (result_ok) state_nx = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state <= state_nx;
            if (AIn) a_q <= Bus;
            if (BIn) b_q <= Bus;
            if (result_ok) flags_q <= FlagsIn;
            if (SumOut && !result_ok) err_q[0] <= 1'b1;
            if (conflict) err_q[1] <= 1'b1;
        end
    end

    assign Reg1  = a_q;
    assign Reg2  = b_q;
    assign Flags = flags_q;
    assign Ready = (state == READY);
    assign Err   = err_q;

endmodule

// File: tb/tb_alu_operand_regs.sv
// Directed self-checking bench for alu_operand_regs; expected values are
// hand-computed from the register/FSM behaviour.
module tb_alu_operand_regs;

    logic        Clk = 1'b0;
    logic        Rst;
    wire  [15:0] Bus;
    logic        AIn, BIn, AOut, BOut, SumOut;
    logic [1:0]  FlagsIn;
    logic [15:0] Reg1, Reg2;
    logic [1:0]  Flags;
    logic        Ready;
    logic [1:0]  Err;

    logic        tb_en;
    logic [15:0] tb_val;

    int checks = 0;
    int errors = 0;

    // Bench side of the shared bus (stands in for the ALU / other sources).
    assign Bus = tb_en ? tb_val : 16'bz;

    always #5 Clk = ~Clk;

    alu_operand_regs #(.WIDTH(16)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Bus    (Bus),
        .AIn    (AIn),
        .BIn    (BIn),
        .AOut   (AOut),
        .BOut   (BOut),
        .SumOut (SumOut),
        .FlagsIn(FlagsIn),
        .Reg1   (Reg1),
        .Reg2   (Reg2),
        .Flags  (Flags),
        .Ready  (Ready),
        .Err    (Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        AIn = 0; BIn = 0; AOut = 0; BOut = 0; SumOut = 0;
        tb_en = 0; tb_val = 16'h0000;
    endtask

    task automatic drive(input logic [15:0] v);
        tb_en  = 1;
        tb_val = v;
    endtask

    initial begin
        Rst = 0; FlagsIn = 2'b00;
        idle();
        #2;
        check("rst_reg1",  Reg1,  0);
        check("rst_reg2",  Reg2,  0);
        check("rst_flags", Flags, 0);
        check("rst_err",   Err,   0);
        check("rst_ready", Ready, 0);
        #10 Rst = 1;

        // Sequential A then B load
        drive(16'h1234); AIn = 1;
        tick();
        check("a_load_reg1",  Reg1,  16'h1234);
        check("a_load_ready", Ready, 0);
        idle(); drive(16'h00FF); BIn = 1;
        tick();
        check("ab_reg1",  Reg1,  16'h1234);
        check("ab_reg2",  Reg2,  16'h00FF);
        check("ab_ready", Ready, 1);

        // Accepted result in READY
        idle(); drive(16'hBEEF); SumOut = 1; FlagsIn = 2'b10;
        tick();
        check("sum_flags", Flags, 2'b10);
        check("sum_ready", Ready, 0);
        check("sum_reg1",  Reg1,  16'h1234);
        check("sum_reg2",  Reg2,  16'h00FF);
        check("sum_err",   Err,   2'b00);

        // Result from EMPTY is a sequence error
        idle(); drive(16'h0000); SumOut = 1; FlagsIn = 2'b01;
        tick();
        check("seq_err",   Err,   2'b01);
        check("seq_flags", Flags, 2'b10);
        check("seq_ready", Ready, 0);

        // Both loads from EMPTY
        idle(); drive(16'h0007); AIn = 1; BIn = 1;
        tick();
        check("both_reg1",  Reg1,  16'h0007);
        check("both_reg2",  Reg2,  16'h0007);
        check("both_ready", Ready, 1);

        // Reload A in READY, then drive it
        idle(); drive(16'hAAAA); AIn = 1;
        tick();
        check("reload_reg1",  Reg1,  16'hAAAA);
        check("reload_ready", Ready, 1);
        idle(); AOut = 1;
        #1;
        check("aout_bus", Bus, 16'hAAAA);
        idle(); BOut = 1;
        #1;
        check("bout_bus", Bus, 16'h0007);
        // Self-reload while driving: no conflict, value kept
        idle(); AOut = 1; AIn = 1;
        tick();
        check("selfload_reg1", Reg1, 16'hAAAA);
        check("selfload_err",  Err,  2'b01);
        // Conflict: DUT must release the bus so only the bench value shows
        idle(); AOut = 1; BOut = 1; drive(16'h0000);
        #1;
        check("conf_bus", Bus, 16'h0000);
        tick();
        check("conf_err", Err, 2'b11);

        // Load with result in READY: loads happen, flags latch, back to EMPTY
        idle(); drive(16'h5555); SumOut = 1; AIn = 1; FlagsIn = 2'b01;
        tick();
        check("sumload_reg1",  Reg1,  16'h5555);
        check("sumload_flags", Flags, 2'b01);
        check("sumload_ready", Ready, 0);

        // Into HAVE_A, reload stays HAVE_A
        idle(); drive(16'h1111); AIn = 1;
        tick();
        check("havea_ready", Ready, 0);
        idle(); drive(16'h2222); AIn = 1;
        tick();
        check("havea2_reg1",  Reg1,  16'h2222);
        check("havea2_ready", Ready, 0);

        // Asynchronous reset pulse between edges
        idle();
        #3 Rst = 0;
        #1;
        check("arst_reg1",  Reg1,  0);
        check("arst_reg2",  Reg2,  0);
        check("arst_flags", Flags, 0);
        check("arst_err",   Err,   0);
        check("arst_ready", Ready, 0);
        #1 Rst = 1;

        // BIn alone after release -> HAVE_B
        drive(16'h3333); BIn = 1;
        tick();
        check("haveb_reg2",  Reg2,  16'h3333);
        check("haveb_ready", Ready, 0);
        // Result with load in HAVE_B: error, B reloaded, stays HAVE_B
        idle(); drive(16'h6666); BIn = 1; SumOut = 1; FlagsIn = 2'b11;
        tick();
        check("haveb_seq_err",   Err,   2'b01);
        check("haveb_seq_reg2",  Reg2,  16'h6666);
        check("haveb_seq_flags", Flags, 2'b00);
        check("haveb_seq_ready", Ready, 0);
        idle(); drive(16'h4444); AIn = 1;
        tick();
        check("haveb_a_reg1",  Reg1,  16'h4444);
        check("haveb_a_ready", Ready, 1);

        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
